// File: rtl/cnn_pkg.sv
// Shared CNN datapath types: int8 pixel type and saturation limits.
// Also used by the requantizer; keep DATA_W in sync with pix_t.
package cnn_pkg;
    localparam int DATA_W   = 8;
    localparam int INT8_MAX = 127;
    localparam int INT8_MIN = -128;

    typedef logic signed [DATA_W-1:0] pix_t;

    // $clog2 that never returns 0, so a 1-entry range still gets a 1-bit index.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/maxpool2x2_stream_if.sv
// Pixel stream in/out of the 2x2 max-pool stage. The master drives pixels in;
// the slave (the pool) returns pooled pixels.
interface maxpool2x2_stream_if #(
    parameter int DATA_W = 8
);
    logic                     valid_in;
    logic signed [DATA_W-1:0] data_in;
    logic                     valid_out;
    logic signed [DATA_W-1:0] data_out;
    logic                     frame_done;

    modport master (output valid_in, data_in, input valid_out, data_out, frame_done);
    modport slave  (input valid_in, data_in, output valid_out, data_out, frame_done);
endinterface

// File: rtl/maxpool2x2_stream_line_buf.sv
// Half-width line buffer: single port, synchronous write, asynchronous read.
// Contents are deliberately not reset so the array maps to distributed RAM.
module pool_line_buf #(
    parameter int DEPTH = 14,
    parameter int WIDTH = 8,
    localparam int AW   = cnn_pkg::clog2_min1(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[addr] <= wdata;
    end

    assign rdata = mem_q[addr];
endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2/stride-2 signed max-pool with a half-width line buffer.
// Define MAXPOOL_RELU_EN to clamp negative pooled results to 0 (fused ReLU).
module maxpool2x2_stream #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    maxpool2x2_stream_if.slave s
);
    import cnn_pkg::*;

    localparam int CW    = clog2_min1(IMG_W);
    localparam int RW    = clog2_min1(IMG_H);
    localparam int DEPTH = IMG_W / 2;
    localparam int AW    = clog2_min1(DEPTH);

    if (IMG_W % 2 != 0) begin : g_bad_w
        $error("maxpool2x2_stream: IMG_W must be even");
    end
    if (IMG_H % 2 != 0) begin : g_bad_h
        $error("maxpool2x2_stream: IMG_H must be even");
    end

    logic [CW-1:0]            col_q, col_d;
    logic [RW-1:0]            row_q, row_d;
    logic signed [DATA_W-1:0] hold_q, hold_d, dout_q, dout_d;
    logic                     vout_q, vout_d, fd_q, fd_d;
    logic signed [DATA_W-1:0] din, h, lb_rd, pooled, pooled_out;
    logic                     lb_we, col_last, row_last;
    logic [AW-1:0]            lb_addr;

    assign din      = s.data_in;
    assign col_last = (col_q == CW'(IMG_W - 1));
    assign row_last = (row_q == RW'(IMG_H - 1));
    assign lb_addr  = AW'(col_q >> 1);
    assign h        = (hold_q > din) ? hold_q : din;
    assign pooled   = (lb_rd > h) ? lb_rd : h;

`ifdef MAXPOOL_RELU_EN
    assign pooled_out = pooled[DATA_W-1] ? '0 : pooled;
`else
    assign pooled_out = pooled;
`endif

    pool_line_buf #(.DEPTH(DEPTH), .WIDTH(DATA_W)) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .addr  (lb_addr),
        .wdata (h),
        .rdata (lb_rd)
    );

    always_comb begin
        col_d  = col_q;
        row_d  = row_q;
        hold_d = hold_q;
        dout_d = dout_q;
        vout_d = 1'b0;
        fd_d   = 1'b0;
        lb_we  = 1'b0;
        if (clear) begin
            col_d  = '0;
            row_d  = '0;
            hold_d = '0;
        end else if (s.valid_in) begin
            // Even column opens a horizontal pair; odd column closes it.
            if (!col_q[0]) begin
                hold_d = din;
            end else if (!row_q[0]) begin
                lb_we = 1'b1;
            end else begin
                vout_d = 1'b1;
                dout_d = pooled_out;
                fd_d   = col_last && row_last;
            end
            if (col_last) begin
                col_d = '0;
                row_d = row_last ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            hold_q <= '0;
            dout_q <= '0;
            vout_q <= 1'b0;
            fd_q   <= 1'b0;
        end else begin
            col_q  <= col_d;
            row_q  <= row_d;
            hold_q <= hold_d;
            dout_q <= dout_d;
            vout_q <= vout_d;
            fd_q   <= fd_d;
        end
    end

    assign s.valid_out  = vout_q;
    assign s.data_out   = dout_q;
    assign s.frame_done = fd_q;
endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream: a 4x2 instance for hand-computed frames
// and a 28x28 instance fed with idle gaps against a small reference model.
module tb_maxpool2x2_stream;
    import cnn_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clr4 = 1'b0;
    logic clr28 = 1'b0;
    always #5 clk = ~clk;

    maxpool2x2_stream_if #(.DATA_W(8)) i4 ();
    maxpool2x2_stream_if #(.DATA_W(8)) i28 ();

    maxpool2x2_stream #(.DATA_W(8), .IMG_W(4), .IMG_H(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .clear(clr4), .s(i4));
    maxpool2x2_stream #(.DATA_W(8), .IMG_W(28), .IMG_H(28)) dut28 (
        .clk(clk), .rst_n(rst_n), .clear(clr28), .s(i28));

    int errs = 0;
    int checks = 0;
    int q4[$];
    int f4[$];
    int q28[$];
    int nfd4 = 0;
    int nfd28 = 0;

    always @(negedge clk) begin
        if (i4.valid_out) begin
            q4.push_back(int'(i4.data_out));
            f4.push_back(int'(i4.frame_done));
        end
        if (i4.frame_done) nfd4++;
        if (i28.valid_out) q28.push_back(int'(i28.data_out));
        if (i28.frame_done) nfd28++;
    end

    task automatic chk(input string tag, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int relu(input int x);
`ifdef MAXPOOL_RELU_EN
        return (x < 0) ? 0 : x;
`else
        return x;
`endif
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    task automatic px4(input int v);
        @(negedge clk);
        i4.valid_in = 1'b1;
        i4.data_in  = pix_t'(v);
    endtask

    task automatic idle4();
        @(negedge clk);
        i4.valid_in = 1'b0;
    endtask

    task automatic frame4(input int p[8]);
        for (int i = 0; i < 8; i++) px4(p[i]);
    endtask

    task automatic settle();
        repeat (3) @(negedge clk);
        #2;
    endtask

    task automatic expect4(input string tag, input int n, input int ev[4], input int ef[4]);
        chk({tag, "_count"}, q4.size(), n);
        for (int i = 0; i < n && i < q4.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), q4[i], ev[i]);
            chk($sformatf("%s_fd%0d", tag, i), f4[i], ef[i]);
        end
        q4.delete();
        f4.delete();
    endtask

    int fa[8] = '{1, 5, 2, 3, 4, 0, 9, -7};
    int fn[8] = '{-1, -5, -2, -3, -4, 0, -9, 7};
    int fm[8] = '{-128, -128, -128, -128, -128, -128, -128, -128};
    int img[28][28];
    int e[4];
    int f[4];
    int fd_before;

    initial begin
        i4.valid_in  = 1'b0;
        i4.data_in   = '0;
        i28.valid_in = 1'b0;
        i28.data_in  = '0;
        #3;
        chk("rst_valid_out", int'(i4.valid_out), 0);
        chk("rst_data_out", int'(i4.data_out), 0);
        chk("rst_frame_done", int'(i4.frame_done), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic frame, with latency and single-cycle pulse checks.
        frame4(fa);
        idle4();
        chk("lat_valid_out", int'(i4.valid_out), 1);
        chk("lat_data_out", int'(i4.data_out), 9);
        chk("lat_frame_done", int'(i4.frame_done), 1);
        @(negedge clk);
        chk("pulse_valid_out", int'(i4.valid_out), 0);
        chk("hold_data_out", int'(i4.data_out), 9);
        chk("pulse_frame_done", int'(i4.frame_done), 0);
        settle();
        e = '{5, 9, 0, 0}; f = '{0, 1, 0, 0};
        expect4("basic", 2, e, f);

        // Negated frame: a 0 and a positive 7 survive both builds.
        frame4(fn);
        idle4();
        settle();
        e = '{0, 7, 0, 0};
        expect4("neg", 2, e, f);

        // Most-negative input: passes through raw, clamps under ReLU.
        frame4(fm);
        idle4();
        settle();
        e = '{relu(-128), relu(-128), 0, 0};
        expect4("min", 2, e, f);

        // Two frames back to back with no idle cycle between.
        fd_before = nfd4;
        frame4(fa);
        frame4(fn);
        idle4();
        settle();
        e = '{5, 9, 0, 7}; f = '{0, 1, 0, 1};
        expect4("b2b", 4, e, f);
        chk("b2b_fd_pulses", nfd4 - fd_before, 2);

        // Clear with a coincident pixel that would otherwise close window 0.
        for (int i = 0; i < 5; i++) px4(100);
        @(negedge clk);
        clr4 = 1'b1;
        i4.valid_in = 1'b1;
        i4.data_in  = pix_t'(100);
        @(negedge clk);
        clr4 = 1'b0;
        i4.valid_in = 1'b0;
        chk("clear_valid_out", int'(i4.valid_out), 0);
        frame4(fa);
        idle4();
        settle();
        e = '{5, 9, 0, 0}; f = '{0, 1, 0, 0};
        expect4("clear", 2, e, f);

        // Asynchronous reset in the middle of row 1, just after an output.
        for (int i = 0; i < 6; i++) px4(fa[i]);
        idle4();
        chk("prerst_valid_out", int'(i4.valid_out), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_valid_out", int'(i4.valid_out), 0);
        chk("async_rst_data_out", int'(i4.data_out), 0);
        chk("async_rst_frame_done", int'(i4.frame_done), 0);
        q4.delete();
        f4.delete();
        @(negedge clk);
        rst_n = 1'b1;
        frame4(fa);
        idle4();
        settle();
        expect4("after_rst", 2, e, f);

        // 28x28 frame with random idle gaps, checked against a reference.
        foreach (img[r, c]) img[r][c] = int'($urandom_range(0, 255)) - 128;
        img[0][0]   = -128;
        img[0][1]   = -128;
        img[1][0]   = -128;
        img[1][1]   = -128;
        img[27][27] = 127;
        for (int r = 0; r < 28; r++) begin
            for (int c = 0; c < 28; c++) begin
                int g;
                @(negedge clk);
                i28.valid_in = 1'b1;
                i28.data_in  = pix_t'(img[r][c]);
                g = int'($urandom_range(0, 3));
                for (int k = 0; k < g; k++) begin
                    @(negedge clk);
                    i28.valid_in = 1'b0;
                end
            end
        end
        @(negedge clk);
        i28.valid_in = 1'b0;
        settle();
        chk("big_count", q28.size(), 196);
        for (int pr = 0; pr < 14; pr++) begin
            for (int pc = 0; pc < 14; pc++) begin
                int idx;
                int m;
                idx = pr * 14 + pc;
                m = max2(max2(img[2*pr][2*pc], img[2*pr][2*pc+1]),
                         max2(img[2*pr+1][2*pc], img[2*pr+1][2*pc+1]));
                if (idx < q28.size())
                    chk($sformatf("big_r%0d_c%0d", pr, pc), q28[idx], relu(m));
            end
        end
        chk("big_fd_pulses", nfd28, 1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
